// File: rtl/zion_skid_reg_slice.sv
// ---------------------------------------------------------------------------
// zion_skid_reg_slice
//
// Two-entry valid/ready register slice (skid buffer). It cuts timing paths in
// both directions of a streaming interface and sustains one beat per cycle.
// All outputs come straight from flops. No input reaches an output through
// combinational logic.
//
// Handshake rule: a beat moves across an interface on a rising clock edge
// when valid and ready are both high. Once the producer raises valid, it
// must hold valid and data stable until that happens.
//
// Parameters:
//   WIDTH    - data width in bits (>= 1)
//   INI_DATA - value loaded into both data registers on reset and on clear
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   iClr - synchronous clear, flushes the slice (overrides any handshake)
//   iVld - upstream valid          oRdy - upstream ready
//   iDat - upstream data
//   oVld - downstream valid        iRdy - downstream ready
//   oDat - downstream data
//   oCnt - occupancy 0..2; this is also the FSM state
// ---------------------------------------------------------------------------
module zion_skid_reg_slice #(
    parameter int unsigned           WIDTH    = 8,
    parameter logic [WIDTH-1:0]      INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [1:0]       oCnt
);

    if (WIDTH < 1) begin : g_bad_width
        $error("zion_skid_reg_slice: WIDTH must be >= 1");
    end

    // The state value is the occupancy, so oCnt exposes the FSM state directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mainDat;
    logic [WIDTH-1:0] skidDat;
    logic             mainVld;
    logic             skidVld;
    logic             inAcc;
    logic             outAcc;

    // mainVld/skidVld are views of the state. skidVld can only be set when
    // mainVld is also set.
    assign mainVld = (state != EMPTY);
    assign skidVld = (state == FULL);

    assign oVld = mainVld;
    assign oDat = mainDat;
    assign oRdy = !skidVld;
    assign oCnt = state;

    assign inAcc  = iVld & oRdy;
    assign outAcc = oVld & iRdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            mainDat <= INI_DATA;
            skidDat <= INI_DATA;
        end else if (iClr) begin
            // A clear drops both handshakes in this cycle, including an
            // outgoing beat that iRdy would otherwise have taken.
            state   <= EMPTY;
            mainDat <= INI_DATA;
            skidDat <= INI_DATA;
        end else begin
            case (state)
                EMPTY: begin
                    if (inAcc) begin
                        state   <= ONE;
                        mainDat <= iDat;
                    end
                end
                ONE: begin
                    if (inAcc && outAcc) begin
                        mainDat <= iDat;
                    end else if (inAcc) begin
                        // The downstream stalled while a beat was arriving.
                        // Park the new beat in skid. oRdy drops next cycle.
                        state   <= FULL;
                        skidDat <= iDat;
                    end else if (outAcc) begin
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    // oRdy is low in this state, so no input is accepted.
                    if (outAcc) begin
                        state   <= ONE;
                        mainDat <= skidDat;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zion_skid_reg_slice.sv
module tb_zion_skid_reg_slice;

    localparam logic [7:0] INI = 8'hA5;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iClr = 1'b0;
    logic        iVld = 1'b0;
    logic        iRdy = 1'b0;
    logic [7:0]  iDat = 8'h00;
    logic        oRdy, oVld;
    logic [7:0]  oDat;
    logic [1:0]  oCnt;

    logic        w1_rdy, w1_vld;
    logic [0:0]  w1_dat;
    logic [1:0]  w1_cnt;
    logic        w64_rdy, w64_vld;
    logic [63:0] w64_dat;
    logic [1:0]  w64_cnt;

    always #5 clk = ~clk;

    zion_skid_reg_slice #(.WIDTH(8), .INI_DATA(INI)) dut (
        .clk(clk), .rst(rst), .iClr(iClr), .iVld(iVld), .oRdy(oRdy),
        .iDat(iDat), .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oCnt(oCnt)
    );

    zion_skid_reg_slice #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .iClr(iClr), .iVld(iVld), .oRdy(w1_rdy),
        .iDat(iDat[0:0]), .oVld(w1_vld), .iRdy(iRdy), .oDat(w1_dat), .oCnt(w1_cnt)
    );

    zion_skid_reg_slice #(.WIDTH(64)) dut_w64 (
        .clk(clk), .rst(rst), .iClr(iClr), .iVld(iVld), .oRdy(w64_rdy),
        .iDat({8{iDat}}), .oVld(w64_vld), .iRdy(iRdy), .oDat(w64_dat), .oCnt(w64_cnt)
    );

    // ---------------- scoreboard / reference model ----------------
    // The slice is modelled as a FIFO of at most two beats. oDat shows the
    // head of the FIFO, or the last value shown once the FIFO is empty.
    logic [7:0] exp_q[$];
    logic [7:0] exp_hold;
    bit         last_in_acc;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_hold = INI;
    endtask

    // Drive one cycle of inputs, advance the model across the edge and return
    // at the falling edge, where outputs are checked.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        bit in_acc;
        bit out_acc;
        iVld = v; iDat = d; iRdy = r; iClr = c;
        @(posedge clk);
        in_acc = 1'b0;
        if (c) begin
            model_reset();
        end else begin
            in_acc  = v && (exp_q.size() < 2);
            out_acc = r && (exp_q.size() > 0);
            if (out_acc) void'(exp_q.pop_front());
            if (in_acc)  exp_q.push_back(d);
            if (exp_q.size() > 0) exp_hold = exp_q[0];
        end
        last_in_acc = in_acc;
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".vld"}, 64'(oVld), 64'(exp_q.size() > 0));
        chk({tag, ".rdy"}, 64'(oRdy), 64'(exp_q.size() < 2));
        chk({tag, ".cnt"}, 64'(oCnt), 64'(exp_q.size()));
        chk({tag, ".dat"}, 64'(oDat), 64'(exp_hold));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       clr;
        logic       e_vld;
        logic       e_rdy;
        logic [1:0] e_cnt;
        logic [7:0] e_dat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic       pv;
        logic [7:0] pd;
        bit         pending;
        logic       r, c;

        // stall sequence
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h01};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h01};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h01};
        vecs[3]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h02};
        vecs[4]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h03};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h03};
        // clear while FULL, with a beat offered and iRdy high
        vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
        vecs[7]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        vecs[8]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, INI};
        vecs[9]  = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, INI};
        // clear on an empty slice drops the offered beat
        vecs[10] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, INI};
        vecs[11] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h44};

        model_reset();
        repeat (2) @(negedge clk);
        chk("por.vld", 64'(oVld), 64'd0);
        chk("por.rdy", 64'(oRdy), 64'd1);
        chk("por.cnt", 64'(oCnt), 64'd0);
        chk("por.dat", 64'(oDat), 64'(INI));
        rst = 1'b0;

        // table-driven stall / clear
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].vld, vecs[i].dat, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d.vld", i), 64'(oVld), 64'(vecs[i].e_vld));
            chk($sformatf("vec%0d.rdy", i), 64'(oRdy), 64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d.cnt", i), 64'(oCnt), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d.dat", i), 64'(oDat), 64'(vecs[i].e_dat));
        end

        // streaming 0x01..0x10 at full rate, on all three widths
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            chk($sformatf("strm%0d.dat", i), 64'(oDat), 64'(i));
            chk($sformatf("strm%0d.vld", i), 64'(oVld), 64'd1);
            chk($sformatf("strm%0d.rdy", i), 64'(oRdy), 64'd1);
            chk($sformatf("strm%0d.cnt", i), 64'(oCnt), 64'd1);
            chk($sformatf("strm%0d.w1", i), 64'(w1_dat), 64'(i % 2));
            chk($sformatf("strm%0d.w64", i), w64_dat, {8{8'(i)}});
            chk($sformatf("strm%0d.w64cnt", i), 64'(w64_cnt), 64'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_model("strm_end");

        // asynchronous reset while FULL, between clock edges
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h6B, 1'b0, 1'b0);
        check_model("pre_rst");
        #2 rst = 1'b1;
        #1;
        chk("arst.vld", 64'(oVld), 64'd0);
        chk("arst.rdy", 64'(oRdy), 64'd1);
        chk("arst.cnt", 64'(oCnt), 64'd0);
        chk("arst.dat", 64'(oDat), 64'(INI));
        model_reset();
        iVld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // first beat is taken on the first edge after release
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check_model("post_rst");

        // randomized traffic against the FIFO model
        pending = 1'b0;
        pv = 1'b0;
        pd = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            if (!pending) begin
                pv = 1'($urandom_range(0, 1));
                pd = 8'($urandom);
            end
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 99) < 5);
            step(pv, pd, r, c);
            pending = pv && !last_in_acc && !c;
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
